hilo_mult_ctrl: RTL
===================

Name: hilo_mult_ctrl

Overview:
Sequences the 32-bit signed multiplier on behalf of the CPU control unit for MULT, and owns the architectural HI/LO registers read by MFHI/MFLO and written by MTHI/MTLO. The multiplier returns only one 32-bit half per request, so the controller issues two back-to-back requests: low word, then high word. It commits HI and LO atomically and reports busy/done to the multicycle FSM. A watchdog aborts a request the multiplier never answers.

Parameters:
W, 32, operand and result half width; the multiplier is fixed at 32.
TIMEOUT, 16, max cycles spent in a WAIT state before abort; must be >= 3.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  MULT issue strobe; sampled only in IDLE
src_a  in  W  rs operand, signed
src_b  in  W  rt operand, signed
mthi_we  in  1  write HI from wdata
mtlo_we  in  1  write LO from wdata
wdata  in  W  MTHI/MTLO data
hi  out  W  architectural HI
lo  out  W  architectural LO
busy  out  1  multiply in flight; CPU stalls MFHI/MFLO/MT*/MULT while high
done  out  1  1-cycle pulse on HI/LO commit
err  out  1  sticky timeout flag
err_clr  in  1  clears err
mul_valid_in  out  1  request to multiplier
mul_lo_hi  out  1  1 = low word, 0 = high word
mul_a  out  W  latched src_a
mul_b  out  W  latched src_b
mul_result  in  W  multiplier result half
mul_valid_out  in  1  multiplier result valid pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- All outputs and registers are registered. On reset: hi = lo = 0, busy = done = err = 0, mul_valid_in = mul_lo_hi = 0, mul_a = mul_b = 0, state = IDLE, timeout counter = 0, lo_shadow = 0.
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI.
- IDLE: when start = 1, latch src_a/src_b into mul_a/mul_b and go to REQ_LO. busy rises on the same edge.
- REQ_LO: mul_valid_in = 1 and mul_lo_hi = 1 for exactly one cycle, then go to WAIT_LO.
- WAIT_LO: on a sampled mul_valid_out = 1, capture mul_result into lo_shadow and go to REQ_HI.
- REQ_HI: mul_valid_in = 1 and mul_lo_hi = 0 for one cycle, then go to WAIT_HI.
- WAIT_HI: on a sampled mul_valid_out = 1, commit hi <= mul_result and lo <= lo_shadow on the same edge. On that edge done = 1, busy = 0, and state returns to IDLE.
- Latency: with start sampled at edge 0 and a 2-cycle multiplier, done is high in the cycle after edge 6. The next start is accepted in that same done cycle.
- mul_a/mul_b stay stable from latch until the next accepted start.
- Watchdog:
  - The counter resets on entry to each WAIT state and increments every WAIT cycle.
  - At count = TIMEOUT - 1 without mul_valid_out: set err, return to IDLE, drop busy, no done, hi/lo unchanged.
  - err clears only on err_clr. If err_clr and a new timeout coincide, err stays set.
- Stray mul_valid_out in IDLE or a REQ state is ignored.
- MTHI/MTLO: honoured only in IDLE with busy = 0, and take effect next edge.
  - Both strobes in one cycle write wdata to both registers.
  - Writes while busy are dropped.
  - start together with mt*_we in IDLE: the write applies now, and the later commit overwrites both registers.
- start while busy is ignored.
- Reset mid-operation returns to reset values immediately. No partial HI/LO commit ever occurs.

Test Plan:
- src_a = 3, src_b = -4, start pulse, responsive 2-cycle multiplier model -> exactly two mul_valid_in pulses (lo_hi 1 then 0); done in cycle 6; lo = 0xFFFFFFF4, hi = 0xFFFFFFFF; busy high cycles 1-5.
- 0x00010000 x 0x00010000, then 0x7FFFFFFF x 0x7FFFFFFF started in the done cycle -> first commit hi = 1, lo = 0; second hi = 0x3FFFFFFF, lo = 0x00000001; no idle gap.
- mthi_we with wdata = 0xDEADBEEF while busy, then mtlo_we with wdata = 0x12345678 in IDLE -> HI is the multiply result; LO = 0x12345678 one cycle later.
- Model never asserts mul_valid_out, TIMEOUT = 16 -> err set 16 cycles after entering WAIT_LO; busy drops; no done; hi/lo keep prior values; err_clr clears err.
- Stray mul_valid_out pulse in IDLE -> no state change, hi/lo unchanged.
- rst_n low during WAIT_HI -> hi = lo = 0, busy = 0, no done; a fresh start after release completes normally.

Source files
------------

// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl
//   Runs a signed 32x32 MULT on an external multiplier that returns one
//   32-bit half per request. Two back-to-back requests are issued (low word
//   first, then high word), and HI/LO are committed together when the high
//   word arrives. Also owns the architectural HI/LO registers for
//   MFHI/MFLO/MTHI/MTLO, and aborts a request the multiplier never answers.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               MULT issue strobe (honoured only when idle)
//   src_a, src_b        signed operands (rs, rt)
//   mthi_we, mtlo_we    write HI / LO from wdata (honoured only when idle)
//   wdata               MTHI/MTLO data
//   hi, lo              architectural HI / LO
//   busy                multiply in flight
//   done                one-cycle pulse on HI/LO commit
//   err, err_clr        sticky watchdog timeout flag and its clear
//   mul_valid_in        request strobe to the multiplier
//   mul_lo_hi           1 = request low word, 0 = request high word
//   mul_a, mul_b        latched operands presented to the multiplier
//   mul_result          returned result half
//   mul_valid_out       result valid pulse from the multiplier

module hilo_mult_ctrl #(
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         mthi_we,
  input  logic         mtlo_we,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic         err_clr,
  output logic         mul_valid_in,
  output logic         mul_lo_hi,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_result,
  input  logic         mul_valid_out
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    WAIT_LO,
    REQ_HI,
    WAIT_HI
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] wd_cnt;
  logic [W-1:0]  lo_shadow;
  logic          wd_expired;
  logic          latch_ops;
  logic          capture_lo;
  logic          commit;
  logic          timeout;
  logic          mt_ok;

  assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));

  // A returning result wins over the watchdog in the final WAIT cycle.
  always_comb begin
    state_next = state;
    latch_ops  = 1'b0;
    capture_lo = 1'b0;
    commit     = 1'b0;
    timeout    = 1'b0;
    mt_ok      = 1'b0;
    case (state)
      IDLE: begin
        mt_ok = 1'b1;
        if (start) begin
          latch_ops  = 1'b1;
          state_next = REQ_LO;
        end
      end
      REQ_LO: state_next = WAIT_LO;
      WAIT_LO: begin
        if (mul_valid_out) begin
          capture_lo = 1'b1;
          state_next = REQ_HI;
        end else if (wd_expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      REQ_HI: state_next = WAIT_HI;
      WAIT_HI: begin
        if (mul_valid_out) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else if (wd_expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every output is registered from the next state, so busy/mul_valid_in
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wd_cnt       <= '0;
      lo_shadow    <= '0;
      hi           <= '0;
      lo           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mul_valid_in <= 1'b0;
      mul_lo_hi    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
    end else begin
      state        <= state_next;
      busy         <= (state_next != IDLE);
      done         <= commit;
      err          <= timeout | (err & ~err_clr);
      mul_valid_in <= (state_next == REQ_LO) || (state_next == REQ_HI);

      if (state_next == REQ_LO) begin
        mul_lo_hi <= 1'b1;
      end else if (state_next == REQ_HI) begin
        mul_lo_hi <= 1'b0;
      end

      if (latch_ops) begin
        mul_a <= src_a;
        mul_b <= src_b;
      end

      if (capture_lo) begin
        lo_shadow <= mul_result;
      end

      // Counter restarts on every entry into a WAIT state.
      if ((state_next == WAIT_LO || state_next == WAIT_HI) && state_next == state) begin
        wd_cnt <= wd_cnt + CW'(1);
      end else begin
        wd_cnt <= '0;
      end

      // Commit and MT* writes are mutually exclusive: MT* only in IDLE.
      if (commit) begin
        hi <= mul_result;
        lo <= lo_shadow;
      end else if (mt_ok) begin
        if (mthi_we) hi <= wdata;
        if (mtlo_we) lo <= wdata;
      end
    end
  end

endmodule
